level_fifo: RTL and testbench
=============================

# level_fifo

Parametrised synchronous FIFO for the UART TX and RX data paths. It replaces the basic buffer with these additions:
- selectable read mode: first-word fall-through or registered;
- programmable almost-full and almost-empty thresholds;
- a fill-level output;
- synchronous flush;
- sticky overflow and underflow error flags;
- write-through when full and a read is accepted in the same cycle.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, depth DEPTH = 2**ADDR_WIDTH words
- FWFT, 1, 1 = fall-through read mode, 0 = registered read mode
- AF_THRESH, 2**ADDR_WIDTH-2, almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH; legal range 0..DEPTH-1

Reset is asynchronous and active-high on `reset`; the clock is `clk`.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush
- wr  in  1  write request
- w_data  in  DATA_WIDTH  write word
- rd  in  1  read/pop request
- r_data  out  DATA_WIDTH  read word
- r_valid  out  1  r_data holds a valid word
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  ADDR_WIDTH+1  number of stored words
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was attempted while empty
- err_clr  in  1  synchronous clear of overflow and underflow

## Operation
- Accept terms:
  - rd_acc = rd & !empty
  - wr_acc = wr & (!full | rd_acc)
  - A write while full is accepted only if a read is accepted in the same cycle.
- Accepted write: mem[w_ptr] <= w_data, then w_ptr increments.
- Accepted read: r_ptr increments.
- Pointers are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- Level update: level <= level + wr_acc - rd_acc. Simultaneous accepted write and read leaves level unchanged.
- FWFT=1:
  - r_data = mem[r_ptr] combinationally.
  - r_valid = !empty.
  - rd pops the presented word.
- FWFT=0:
  - On rd_acc, r_data <= mem[r_ptr] and r_valid <= 1 at the same edge.
  - Otherwise r_valid <= 0 and r_data holds its value.
- overflow sets on wr & !wr_acc. underflow sets on rd & empty.
- Both error flags stay set until err_clr or reset.
- If err_clr and a new error occur in the same cycle, set wins.
- clr:
  - Sets w_ptr, r_ptr and level to 0, and sets r_valid to 0 (FWFT=0 mode).
  - Overrides wr and rd in the same cycle: nothing is accepted and no error flag is set.
  - Leaves overflow, underflow and memory contents unchanged.
- Flags are decoded from the registered level only, with no combinational path from wr or rd.

## Timing
- Reset values:
  - level 0, empty 1, full 0, almost_empty 1, almost_full 0
  - overflow 0, underflow 0, r_valid 0
  - r_data 0 in FWFT=0 mode; don't-care while r_valid=0 in FWFT=1 mode
  - Memory is not reset.
- Write at edge N: level and flags update after edge N. In FWFT=1, the word is on r_data and r_valid=1 from edge N (one-cycle write-to-read latency).
- Read in FWFT=1: data is available in the same cycle as rd. The next word appears after the edge.
- Read in FWFT=0: rd at edge N puts data on r_data with r_valid=1 after edge N, held for one cycle.
- Reset asserted mid-operation clears state immediately, without waiting for clk. Any in-flight read or write is lost.
- After reset deasserts, the first accepted write is on the next rising edge.

## Structure
- Shared package uart_pkg:
  - default DATA_WIDTH and ADDR_WIDTH constants
  - FWFT mode constants FIFO_MODE_FWFT=1 and FIFO_MODE_REG=0
- Sub-module fifo_mem:
  - DEPTH x DATA_WIDTH register array
  - synchronous write port (we, waddr, wdata)
  - asynchronous read port (raddr, rdata)
- level_fifo holds the pointers, level counter, flag decode, error flags and read-register logic.
- Elaboration-time check of the AF_THRESH and AE_THRESH ranges, with a fatal error when either is out of range.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), AF_THRESH=3 and AE_THRESH=1.
1. Fill and drain, FWFT=1:
   - Write 0x11, 0x22, 0x33, 0x44.
   - Required: level steps 1..4; almost_empty clears at level 2; almost_full sets at 3; full sets at 4.
   - Read 4 words. Required: r_data shows 0x11..0x44 in order, then empty=1 and r_valid=0.
2. Overflow:
   - With the FIFO full, write 0x55 with rd=0.
   - Required: level stays 4 and overflow=1.
   - Read all words. Required: no 0x55 is present. err_clr then sets overflow to 0.
3. Write-through when full:
   - With the FIFO full of 0x11..0x44, assert wr=1 (0x55) and rd=1 in one cycle.
   - Required: level stays 4, 0x11 pops, and the next reads return 0x22, 0x33, 0x44, 0x55 (exercises pointer wrap).
4. Underflow and empty collision:
   - With the FIFO empty, assert wr=1 (0xA5) and rd=1 in one cycle.
   - Required: underflow=1, level=1, r_data=0xA5 on the next cycle.
5. FWFT=0 latency:
   - Write 0x3C, then pulse rd at edge N.
   - Required: r_valid=1 and r_data=0x3C only in cycle N+1; r_valid=0 at N+2 with r_data held at 0x3C.
6. Flush and asynchronous reset:
   - At level 3 with overflow=1, assert clr together with wr (0x77).
   - Required: level=0 and empty=1, with overflow still 1.
   - Assert reset between edges. Required: all outputs take their reset values immediately and overflow=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART data-path blocks: default FIFO geometry and read-mode encodings.
package uart_pkg;
  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_ADDR_WIDTH = 4;
  localparam int FIFO_MODE_FWFT  = 1;
  localparam int FIFO_MODE_REG   = 0;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/level_fifo.sv
// Synchronous FIFO with fall-through or registered read, fill level, threshold flags,
// synchronous flush and sticky overflow/underflow flags.
module level_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_ADDR_WIDTH,
  parameter int FWFT       = FIFO_MODE_FWFT,
  parameter int AF_THRESH  = 2**ADDR_WIDTH-2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LV_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LV_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   LV_AE    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH-1 ||
      (FWFT != FIFO_MODE_FWFT && FWFT != FIFO_MODE_REG)) begin : g_bad_param
    $fatal(1, "level_fifo: AF_THRESH/AE_THRESH/FWFT out of range");
  end

  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_ovf, r_udf;
  logic                  w_empty, w_full, w_rd_acc, w_wr_acc, w_set_ovf, w_set_udf;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LV_DEPTH);

  // Flush takes priority: nothing is accepted and no error is flagged in that cycle.
  assign w_rd_acc  = rd & ~w_empty & ~clr;
  assign w_wr_acc  = wr & (~w_full | w_rd_acc) & ~clr;
  assign w_set_ovf = wr & ~w_wr_acc & ~clr;
  assign w_set_udf = rd & w_empty & ~clr;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (w_wr_acc),
    .waddr(r_wptr),
    .wdata(w_data),
    .raddr(r_rptr),
    .rdata(w_mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
      r_level <= r_level + (ADDR_WIDTH+1)'(w_wr_acc) - (ADDR_WIDTH+1)'(w_rd_acc);
    end
  end

  // A fresh error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~err_clr) | w_set_ovf;
      r_udf <= (r_udf & ~err_clr) | w_set_udf;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign r_data  = w_mem_rdata;
    assign r_valid = ~w_empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else if (clr) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_rd_acc;
        if (w_rd_acc) r_rdata <= w_mem_rdata;
      end
    end

    assign r_data  = r_rdata;
    assign r_valid = r_rvalid;
  end

  assign level        = r_level;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_level >= LV_AF);
  assign almost_empty = (r_level <= LV_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
endmodule

// File: tb/tb_level_fifo.sv
// Bench for level_fifo: a fall-through and a registered instance share stimulus and are checked
// every cycle against a list-based model, plus literal expectations from the test plan.
module tb_level_fifo;
  logic       clk = 1'b0, reset = 1'b1, clr = 1'b0, wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
  logic [7:0] w_data = '0;

  logic [7:0] a_rdata, b_rdata;
  logic       a_rvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic       b_rvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] a_level, b_level;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  level_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_a (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(a_rdata), .r_valid(a_rvalid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .level(a_level),
    .overflow(a_ovf), .underflow(a_udf), .err_clr(err_clr));

  level_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_b (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(b_rdata), .r_valid(b_rvalid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .level(b_level),
    .overflow(b_ovf), .underflow(b_udf), .err_clr(err_clr));

  // Model: q[0] is the oldest stored word, n the number stored; v0/d0 the registered-mode read port.
  typedef struct packed {
    logic [3:0][7:0] q;
    logic [2:0]      n;
    logic            ov, un, v0;
    logic [7:0]      d0;
  } mdl_t;
  mdl_t m;

  function automatic mdl_t step(mdl_t s, logic c, logic w, logic [7:0] wd, logic r, logic ec);
    mdl_t t;
    logic ra, wa;
    t = s;
    t.ov = s.ov & ~ec;
    t.un = s.un & ~ec;
    if (c) begin
      t.n  = 3'd0;
      t.v0 = 1'b0;
    end else begin
      ra = r && (s.n != 3'd0);
      wa = w && ((s.n != 3'd4) || ra);
      if (w && !wa) t.ov = 1'b1;
      if (r && s.n == 3'd0) t.un = 1'b1;
      t.v0 = ra;
      if (ra) begin
        t.d0 = s.q[0];
        for (int i = 0; i < 3; i++) t.q[i] = s.q[i+1];
        t.n = s.n - 3'd1;
      end
      if (wa) begin
        t.q[t.n[1:0]] = wd;
        t.n = t.n + 3'd1;
      end
    end
    return t;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m, clr, wr, w_data, rd, err_clr);
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      cmp("a_level", int'(a_level), int'(m.n));
      cmp("b_level", int'(b_level), int'(m.n));
      cmp("a_empty", int'(a_empty), int'(m.n == 3'd0));
      cmp("a_full",  int'(a_full),  int'(m.n == 3'd4));
      cmp("a_af",    int'(a_af),    int'(m.n >= 3'd3));
      cmp("a_ae",    int'(a_ae),    int'(m.n <= 3'd1));
      cmp("b_flags", int'({b_empty, b_full, b_af, b_ae}),
          int'({m.n == 3'd0, m.n == 3'd4, m.n >= 3'd3, m.n <= 3'd1}));
      cmp("a_err",   int'({a_ovf, a_udf}), int'({m.ov, m.un}));
      cmp("b_err",   int'({b_ovf, b_udf}), int'({m.ov, m.un}));
      cmp("a_rvalid", int'(a_rvalid), int'(m.n != 3'd0));
      if (m.n != 3'd0) cmp("a_rdata", int'(a_rdata), int'(m.q[0]));
      cmp("b_rvalid", int'(b_rvalid), int'(m.v0));
      cmp("b_rdata",  int'(b_rdata),  int'(m.d0));
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c, input logic e);
    wr = w; w_data = d; rd = r; clr = c; err_clr = e;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr = 1'b0; err_clr = 1'b0;
  endtask

  logic [7:0] wd4  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] wt4  [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
  logic       x_ae [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic       x_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    @(negedge clk);
    cmp("rst_level", int'(a_level), 0);
    cmp("rst_empty", int'(a_empty), 1);
    cmp("rst_full",  int'(a_full), 0);
    cmp("rst_ae",    int'(a_ae), 1);
    cmp("rst_af",    int'(a_af), 0);
    cmp("rst_err",   int'({a_ovf, a_udf, b_ovf, b_udf}), 0);
    cmp("rst_rvalid", int'({a_rvalid, b_rvalid}), 0);
    cmp("rst_b_rdata", int'(b_rdata), 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1. fill and drain, fall-through
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, wd4[i], 1'b0, 1'b0, 1'b0);
      cmp("s1_level", int'(a_level), i + 1);
      cmp("s1_ae",    int'(a_ae),    int'(x_ae[i]));
      cmp("s1_af",    int'(a_af),    int'(x_af[i]));
      cmp("s1_full",  int'(a_full),  int'(i == 3));
    end
    // 2. overflow, then drain shows the rejected word never entered
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    cmp("s2_level", int'(a_level), 4);
    cmp("s2_ovf",   int'({a_ovf, b_ovf}), 3);
    for (int i = 0; i < 4; i++) begin
      cmp("s1_rdata", int'(a_rdata), int'(wd4[i]));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cmp("s1_b_rdata", int'(b_rdata), int'(wd4[i]));
      cmp("s1_b_rvalid", int'(b_rvalid), 1);
    end
    cmp("s1_empty",  int'(a_empty), 1);
    cmp("s1_rvalid", int'(a_rvalid), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cmp("s2_errclr", int'(a_ovf), 0);

    // 3. write-through when full, across the pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, wd4[i], 1'b0, 1'b0, 1'b0);
    cmp("s3_head", int'(a_rdata), 8'h11);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    cmp("s3_level", int'(a_level), 4);
    cmp("s3_ovf",   int'(a_ovf), 0);
    cmp("s3_b_pop", int'(b_rdata), 8'h11);
    for (int i = 0; i < 4; i++) begin
      cmp("s3_rdata", int'(a_rdata), int'(wt4[i]));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // 4. read and write together on an empty FIFO
    cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    cmp("s4_udf",   int'(a_udf), 1);
    cmp("s4_level", int'(a_level), 1);
    cmp("s4_rdata", int'(a_rdata), 8'hA5);
    cmp("s4_b_rvalid", int'(b_rvalid), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cmp("s4_errclr", int'(a_udf), 0);

    // 5. registered-read latency
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cmp("s5_rvalid_n1", int'(b_rvalid), 1);
    cmp("s5_rdata_n1",  int'(b_rdata), 8'h3C);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cmp("s5_rvalid_n2", int'(b_rvalid), 0);
    cmp("s5_rdata_n2",  int'(b_rdata), 8'h3C);

    // 6. flush with a colliding write, then asynchronous reset
    for (int i = 0; i < 4; i++) cyc(1'b1, wd4[i], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cmp("s6_pre_level", int'(a_level), 3);
    cmp("s6_pre_ovf",   int'(a_ovf), 1);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    cmp("s6_clr_level", int'(a_level), 0);
    cmp("s6_clr_empty", int'(a_empty), 1);
    cmp("s6_clr_ovf",   int'(a_ovf), 1);
    cmp("s6_clr_b_rvalid", int'(b_rvalid), 0);
    cyc(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
    cmp("s6_after_clr", int'(a_rdata), 8'hE1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cmp("s6_b_rdata", int'(b_rdata), 8'hE1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    cmp("s6_rst_level", int'({a_level, b_level}), 0);
    cmp("s6_rst_flags", int'({a_empty, a_full, a_af, a_ae}), 4'b1001);
    cmp("s6_rst_err",   int'({a_ovf, a_udf, b_ovf, b_udf}), 0);
    cmp("s6_rst_rvalid", int'({a_rvalid, b_rvalid}), 0);
    cmp("s6_rst_b_rdata", int'(b_rdata), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    cmp("s6_post_level", int'(a_level), 1);
    cmp("s6_post_rdata", int'(a_rdata), 8'h5A);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
